loop_ctrl_nest: RTL

Nested-loop controller that sits directly upstream of the address/stride memory walkers. It is configured with per-loop iteration counts, then walks the loop nest one step per cycle. Each step emits the index of the loop that advances, plus init/enter/exit/done markers, so every attached walker can add the matching stride. All walkers of one operand group share one instance.

---
 rtl/loop_ctrl_nest_pkg.sv | 22 ++
 rtl/loop_ctrl_nest_loop_iter_buf.sv | 64 ++++++
 rtl/loop_ctrl_nest.sv | 113 +++++++++++
 3 files changed

// File: rtl/loop_ctrl_nest_pkg.sv
// Shared definitions for the nested-loop controller: FSM encoding,
// default widths and the nest depth derived from the loop index width.
package loop_ctrl_nest_pkg;

  localparam int LOOP_ID_W_DEF   = 5;
  localparam int LOOP_ITER_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_BUSY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Number of loop slots addressable with an index of the given width.
  function automatic int depth_of(input int id_w);
    return 1 << id_w;
  endfunction

  localparam int MAX_DEPTH_DEF = depth_of(LOOP_ID_W_DEF);

endpackage

// File: rtl/loop_ctrl_nest_loop_iter_buf.sv
// Per-loop storage of iteration maxima and live counters, plus the
// carry-scan priority encoder that picks the loop advancing next.
module loop_iter_buf
  import loop_ctrl_nest_pkg::*;
#(
  parameter int ID_W   = LOOP_ID_W_DEF,
  parameter int ITER_W = LOOP_ITER_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ID_W-1:0]   wr_addr,
  input  logic [ITER_W-1:0] wr_max,
  input  logic [ID_W-1:0]   num_loops,
  input  logic              clr,
  input  logic              step,
  output logic [ID_W-1:0]   k,
  output logic              all_max
);

  localparam int DEPTH = depth_of(ID_W);

  logic [ITER_W-1:0] max_mem [DEPTH];
  logic [DEPTH-1:0]  at_max;
  logic [DEPTH-1:0]  in_nest;

  // Maxima are only ever rewritten by configuration; no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) max_mem[wr_addr] <= wr_max;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [ITER_W-1:0] cnt;

      // Counter k increments, every counter below k wraps back to zero.
      always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
          cnt <= '0;
        end else if (step) begin
          if (ID_W'(gi) < k)       cnt <= '0;
          else if (ID_W'(gi) == k) cnt <= cnt + 1'b1;
        end
      end

      assign at_max[gi]  = (cnt == max_mem[gi]);
      assign in_nest[gi] = (ID_W'(gi) < num_loops);
    end
  endgenerate

  // Slots outside the configured nest never block completion.
  assign all_max = &(at_max | ~in_nest);

  // Lowest in-nest loop not yet at its maximum; scanning downwards lets
  // the lowest match win without a separate found flag.
  always_comb begin
    k = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (in_nest[i] && !at_max[i]) k = ID_W'(i);
    end
  end

endmodule

// File: rtl/loop_ctrl_nest.sv
// Nested-loop controller: collects per-loop iteration counts, then walks
// the nest one step per cycle and emits registered step/marker pulses.
module loop_ctrl_nest
  import loop_ctrl_nest_pkg::*;
#(
  parameter int LOOP_ID_W   = LOOP_ID_W_DEF,
  parameter int LOOP_ITER_W = LOOP_ITER_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cfg_loop_iter_v,
  input  logic [LOOP_ITER_W-1:0] cfg_loop_iter,
  input  logic                   start,
  input  logic                   stall,
  output logic                   loop_init,
  output logic                   loop_enter,
  output logic [LOOP_ID_W-1:0]   loop_index,
  output logic                   loop_index_valid,
  output logic                   loop_exit,
  output logic                   loop_ctrl_done,
  output logic                   busy
);

  localparam logic [LOOP_ID_W-1:0] PTR_LAST = '1;

  state_t                 state;
  logic [LOOP_ID_W-1:0]   wr_ptr;
  logic [LOOP_ITER_W-1:0] wr_max;
  logic                   cfg_wr;
  logic                   start_ok;
  logic                   clr;
  logic                   step;
  logic                   all_max;
  logic [LOOP_ID_W-1:0]   k;

  // An iteration count of 0 behaves like 1, i.e. a maximum of 0.
  assign wr_max   = (cfg_loop_iter == '0) ? '0 : cfg_loop_iter - 1'b1;
  assign cfg_wr   = cfg_loop_iter_v && (state == ST_IDLE);
  assign start_ok = start && (state == ST_IDLE) && (wr_ptr != '0);
  assign clr      = start_ok || (state == ST_DONE);
  // Completion is detected one cycle after the final step, so a step is
  // taken whenever the nest is not yet complete and downstream is ready.
  assign step     = ((state == ST_INIT) || (state == ST_BUSY)) && !all_max && !stall;

  loop_iter_buf #(
    .ID_W   (LOOP_ID_W),
    .ITER_W (LOOP_ITER_W)
  ) u_iter_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (cfg_wr),
    .wr_addr   (wr_ptr),
    .wr_max    (wr_max),
    .num_loops (wr_ptr),
    .clr       (clr),
    .step      (step),
    .k         (k),
    .all_max   (all_max)
  );

  // Control FSM with every output registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      wr_ptr           <= '0;
      loop_init        <= 1'b0;
      loop_enter       <= 1'b0;
      loop_index       <= '0;
      loop_index_valid <= 1'b0;
      loop_exit        <= 1'b0;
      loop_ctrl_done   <= 1'b0;
      busy             <= 1'b0;
    end else begin
      loop_init        <= 1'b0;
      loop_enter       <= 1'b0;
      loop_index_valid <= 1'b0;
      loop_exit        <= 1'b0;
      loop_ctrl_done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_wr && (wr_ptr != PTR_LAST)) wr_ptr <= wr_ptr + 1'b1;
          if (start_ok) begin
            state      <= ST_INIT;
            loop_init  <= 1'b1;
            loop_enter <= 1'b1;
            loop_index <= '0;
            busy       <= 1'b1;
          end
        end
        ST_INIT, ST_BUSY: begin
          if (all_max) begin
            state          <= ST_DONE;
            loop_exit      <= 1'b1;
            loop_ctrl_done <= 1'b1;
          end else begin
            state <= ST_BUSY;
            if (!stall) begin
              loop_index       <= k;
              loop_index_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          wr_ptr <= '0;
          busy   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
